// File: rtl/attack_knockback.sv
// attack_knockback
//   Per-player attack sequencing for a two-fighter game (Ken = P1, Akuma = P2),
//   hit detection against a fixed reach, knockback generation and stun cancel.
//   Everything advances once per frame on the rising edge of frame_clk.
//
// Ports
//   frame_clk                    frame-rate clock
//   Reset_n                      synchronous, active-low reset
//   keycode_0..keycode_3 [7:0]   current USB HID keycodes
//   KenX, AkumaX         [9:0]   fighter top-left X positions (unsigned)
//   XDist                 int    AkumaX - KenX, combinational
//   Akuma_Knockback       int    per-frame X push applied to Akuma (0 or +KB_SPEED)
//   Ken_Knockback         int    per-frame X push applied to Ken   (0 or -KB_SPEED)
//   P1_State, P2_State   [1:0]   attack FSM state of Ken / Akuma
//   P1_Hit, P2_Hit               one-frame pulse when that player lands a hit
//
// Attack FSM (one instance per player)
//   state       | meaning
//   ST_IDLE     | no attack in progress, waiting for a press edge
//   ST_STARTUP  | wind-up frames, can be cancelled by an incoming hit
//   ST_ACTIVE   | hitbox live, first in-range frame lands the hit
//   ST_RECOVERY | cool-down frames, no hit possible
//
// Phase counters are down-counters loaded with (phase length - 1); a phase
// ends on the frame its counter reads zero, so each phase lasts exactly its
// parameter in frames.
module attack_knockback #(
    parameter int         STARTUP     = 4,
    parameter int         ACTIVE      = 3,
    parameter int         RECOVERY    = 8,
    parameter int         REACH       = 150,
    parameter int         KB_SPEED    = 3,
    parameter int         KB_FRAMES   = 6,
    parameter int         Bound_X_Max = 635,
    parameter logic [7:0] P1_KEY      = 8'h09,
    parameter logic [7:0] P2_KEY      = 8'h10
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode_0,
    input  logic [7:0] keycode_1,
    input  logic [7:0] keycode_2,
    input  logic [7:0] keycode_3,
    input  logic [9:0] KenX,
    input  logic [9:0] AkumaX,
    output int         XDist,
    output int         Akuma_Knockback,
    output int         Ken_Knockback,
    output logic [1:0] P1_State,
    output logic [1:0] P2_State,
    output logic       P1_Hit,
    output logic       P2_Hit
);

    localparam int CW = 8;

    localparam logic [CW-1:0] STARTUP_LD  = CW'(STARTUP - 1);
    localparam logic [CW-1:0] ACTIVE_LD   = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] RECOVERY_LD = CW'(RECOVERY - 1);
    localparam logic [CW-1:0] KB_LD       = CW'(KB_FRAMES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    // Akuma's sprite is 125 px wide; its right edge must stay inside the arena.
    localparam int AKUMA_WIDTH = 125;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STARTUP  = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_RECOVERY = 2'd3
    } atk_state_e;

    typedef struct packed {
        atk_state_e    state;
        logic [CW-1:0] phase;
    } fsm_t;

    localparam fsm_t FSM_IDLE = '{state: ST_IDLE, phase: '0};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fsm_t          p1_fsm_q, p1_fsm_d;
    fsm_t          p2_fsm_q, p2_fsm_d;
    logic          p1_key_prev_q, p1_key_prev_d;
    logic          p2_key_prev_q, p2_key_prev_d;
    logic          p1_hit_done_q, p1_hit_done_d;
    logic          p2_hit_done_q, p2_hit_done_d;
    logic          p1_hit_q, p1_hit_d;
    logic          p2_hit_q, p2_hit_d;
    logic [CW-1:0] akuma_kb_cnt_q, akuma_kb_cnt_d;
    logic [CW-1:0] ken_kb_cnt_q, ken_kb_cnt_d;
    int            akuma_kb_q, akuma_kb_d;
    int            ken_kb_q, ken_kb_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    int   ken_x_i;
    int   akuma_x_i;
    int   x_dist;
    logic in_range;
    logic akuma_at_wall;
    logic ken_at_wall;
    logic p1_pressed, p2_pressed;
    logic p1_edge, p2_edge;
    logic p1_hit_now, p2_hit_now;
    logic trade;

    assign ken_x_i   = {22'd0, KenX};
    assign akuma_x_i = {22'd0, AkumaX};
    assign x_dist    = akuma_x_i - ken_x_i;
    assign XDist     = x_dist;

    // Signed compare: Akuma on Ken's left (negative distance) is still in reach.
    assign in_range      = (x_dist <= REACH);
    assign akuma_at_wall = (akuma_x_i + AKUMA_WIDTH + KB_SPEED >= Bound_X_Max);
    assign ken_at_wall   = (ken_x_i < KB_SPEED);

    assign p1_pressed = (keycode_0 == P1_KEY) || (keycode_1 == P1_KEY) ||
                        (keycode_2 == P1_KEY) || (keycode_3 == P1_KEY);
    assign p2_pressed = (keycode_0 == P2_KEY) || (keycode_1 == P2_KEY) ||
                        (keycode_2 == P2_KEY) || (keycode_3 == P2_KEY);

    assign p1_edge = p1_pressed && !p1_key_prev_q;
    assign p2_edge = p2_pressed && !p2_key_prev_q;

    assign p1_hit_now = (p1_fsm_q.state == ST_ACTIVE) && !p1_hit_done_q && in_range;
    assign p2_hit_now = (p2_fsm_q.state == ST_ACTIVE) && !p2_hit_done_q && in_range;
    assign trade      = p1_hit_now && p2_hit_now;

    // Phase sequencing for one player; press edges outside IDLE are dropped.
    function automatic fsm_t fsm_next(fsm_t cur, logic start);
        fsm_t nxt;
        nxt = cur;
        case (cur.state)
            ST_IDLE: begin
                if (start) begin
                    nxt.state = ST_STARTUP;
                    nxt.phase = STARTUP_LD;
                end
            end
            ST_STARTUP: begin
                if (cur.phase == '0) begin
                    nxt.state = ST_ACTIVE;
                    nxt.phase = ACTIVE_LD;
                end else begin
                    nxt.phase = cur.phase - CNT_ONE;
                end
            end
            ST_ACTIVE: begin
                if (cur.phase == '0) begin
                    nxt.state = ST_RECOVERY;
                    nxt.phase = RECOVERY_LD;
                end else begin
                    nxt.phase = cur.phase - CNT_ONE;
                end
            end
            ST_RECOVERY: begin
                if (cur.phase == '0) begin
                    nxt = FSM_IDLE;
                end else begin
                    nxt.phase = cur.phase - CNT_ONE;
                end
            end
            default: nxt = FSM_IDLE;
        endcase
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        p1_fsm_d       = fsm_next(p1_fsm_q, p1_edge);
        p2_fsm_d       = fsm_next(p2_fsm_q, p2_edge);
        p1_key_prev_d  = p1_pressed;
        p2_key_prev_d  = p2_pressed;
        p1_hit_done_d  = p1_hit_done_q;
        p2_hit_done_d  = p2_hit_done_q;
        p1_hit_d       = p1_hit_now;
        p2_hit_d       = p2_hit_now;
        akuma_kb_cnt_d = akuma_kb_cnt_q;
        ken_kb_cnt_d   = ken_kb_cnt_q;
        akuma_kb_d     = 0;
        ken_kb_d       = 0;

        // One hit per attack: the flag is re-armed when a new attack starts.
        if ((p1_fsm_q.state == ST_IDLE) && p1_edge) begin
            p1_hit_done_d = 1'b0;
        end
        if (p1_hit_now) begin
            p1_hit_done_d = 1'b1;
        end
        if ((p2_fsm_q.state == ST_IDLE) && p2_edge) begin
            p2_hit_done_d = 1'b0;
        end
        if (p2_hit_now) begin
            p2_hit_done_d = 1'b1;
        end

        // Stun cancel: a victim still winding up loses its attack. A trade
        // means both are ACTIVE, so neither is cancelled.
        if (!trade) begin
            if (p1_hit_now && (p2_fsm_q.state == ST_STARTUP)) begin
                p2_fsm_d = FSM_IDLE;
            end
            if (p2_hit_now && (p1_fsm_q.state == ST_STARTUP)) begin
                p1_fsm_d = FSM_IDLE;
            end
        end

        // Knockback duration timers; a new hit restarts the full duration.
        if (p1_hit_now) begin
            akuma_kb_cnt_d = KB_LD;
        end else if (akuma_kb_cnt_q != '0) begin
            akuma_kb_cnt_d = akuma_kb_cnt_q - CNT_ONE;
        end
        if (p2_hit_now) begin
            ken_kb_cnt_d = KB_LD;
        end else if (ken_kb_cnt_q != '0) begin
            ken_kb_cnt_d = ken_kb_cnt_q - CNT_ONE;
        end

        // The push is suppressed at the arena edge but the timer keeps running.
        if ((akuma_kb_cnt_d != '0) && !akuma_at_wall) begin
            akuma_kb_d = KB_SPEED;
        end
        if ((ken_kb_cnt_d != '0) && !ken_at_wall) begin
            ken_kb_d = -KB_SPEED;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            p1_fsm_q       <= FSM_IDLE;
            p2_fsm_q       <= FSM_IDLE;
            p1_key_prev_q  <= 1'b0;
            p2_key_prev_q  <= 1'b0;
            p1_hit_done_q  <= 1'b0;
            p2_hit_done_q  <= 1'b0;
            p1_hit_q       <= 1'b0;
            p2_hit_q       <= 1'b0;
            akuma_kb_cnt_q <= '0;
            ken_kb_cnt_q   <= '0;
            akuma_kb_q     <= 0;
            ken_kb_q       <= 0;
        end else begin
            p1_fsm_q       <= p1_fsm_d;
            p2_fsm_q       <= p2_fsm_d;
            p1_key_prev_q  <= p1_key_prev_d;
            p2_key_prev_q  <= p2_key_prev_d;
            p1_hit_done_q  <= p1_hit_done_d;
            p2_hit_done_q  <= p2_hit_done_d;
            p1_hit_q       <= p1_hit_d;
            p2_hit_q       <= p2_hit_d;
            akuma_kb_cnt_q <= akuma_kb_cnt_d;
            ken_kb_cnt_q   <= ken_kb_cnt_d;
            akuma_kb_q     <= akuma_kb_d;
            ken_kb_q       <= ken_kb_d;
        end
    end

    assign P1_State        = p1_fsm_q.state;
    assign P2_State        = p2_fsm_q.state;
    assign P1_Hit          = p1_hit_q;
    assign P2_Hit          = p2_hit_q;
    assign Akuma_Knockback = akuma_kb_q;
    assign Ken_Knockback   = ken_kb_q;

endmodule

// File: tb/tb_attack_knockback.sv
// Testbench for attack_knockback: table of hand-derived frame vectors for
// the directed scenarios, a held-key sequence, then randomized frames checked
// against a timeline model (attack age in frames since the press edge).
module tb_attack_knockback;

    localparam int STARTUP   = 4;
    localparam int ACTIVE    = 3;
    localparam int RECOVERY  = 8;
    localparam int TOTAL     = STARTUP + ACTIVE + RECOVERY;
    localparam int REACH     = 150;
    localparam int KB_SPEED  = 3;
    localparam int KB_FRAMES = 6;
    localparam int BOUND     = 635;
    localparam logic [7:0] P1_KEY = 8'h09;
    localparam logic [7:0] P2_KEY = 8'h10;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode_0, keycode_1, keycode_2, keycode_3;
    logic [9:0] KenX, AkumaX;
    int         XDist, Akuma_Knockback, Ken_Knockback;
    logic [1:0] P1_State, P2_State;
    logic       P1_Hit, P2_Hit;

    attack_knockback dut (
        .frame_clk       (frame_clk),
        .Reset_n         (Reset_n),
        .keycode_0       (keycode_0),
        .keycode_1       (keycode_1),
        .keycode_2       (keycode_2),
        .keycode_3       (keycode_3),
        .KenX            (KenX),
        .AkumaX          (AkumaX),
        .XDist           (XDist),
        .Akuma_Knockback (Akuma_Knockback),
        .Ken_Knockback   (Ken_Knockback),
        .P1_State        (P1_State),
        .P2_State        (P2_State),
        .P1_Hit          (P1_Hit),
        .P2_Hit          (P2_Hit)
    );

    always #5 frame_clk = ~frame_clk;

    int n_vec = 0;
    int n_err = 0;
    int cur_kx = 0;
    int cur_ax = 0;

    // ---------------- reference model ----------------
    int m_age [2];   // -1 idle, else frames since the attack started
    bit m_done [2];
    bit m_prev [2];
    int m_akc, m_kenc;
    bit e_hit [2];
    int e_akb, e_kkb;

    function automatic int phase_of(int age);
        if (age < 0) return 0;
        if (age < STARTUP) return 1;
        if (age < STARTUP + ACTIVE) return 2;
        if (age < TOTAL) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_age[i] = -1; m_done[i] = 0; m_prev[i] = 0; e_hit[i] = 0;
        end
        m_akc = 0; m_kenc = 0; e_akb = 0; e_kkb = 0;
    endtask

    task automatic model_step(bit rst, bit p1, bit p2, int kx, int ax);
        bit pr [2];
        bit hit [2];
        int ph [2];
        bit in_range;
        if (!rst) begin
            model_reset();
            return;
        end
        pr[0] = p1; pr[1] = p2;
        in_range = ((ax - kx) <= REACH);
        for (int i = 0; i < 2; i++) begin
            ph[i]  = phase_of(m_age[i]);
            hit[i] = (ph[i] == 2) && !m_done[i] && in_range;
        end
        for (int i = 0; i < 2; i++) begin
            if (m_age[i] >= 0) begin
                m_age[i]++;
                if (m_age[i] >= TOTAL) m_age[i] = -1;
            end else if (pr[i] && !m_prev[i]) begin
                m_age[i]  = 0;
                m_done[i] = 0;
            end
            if (hit[i]) m_done[i] = 1;
            m_prev[i] = pr[i];
            e_hit[i]  = hit[i];
        end
        if (!(hit[0] && hit[1])) begin
            if (hit[0] && ph[1] == 1) m_age[1] = -1;
            if (hit[1] && ph[0] == 1) m_age[0] = -1;
        end
        m_akc  = hit[0] ? KB_FRAMES : ((m_akc > 0) ? m_akc - 1 : 0);
        m_kenc = hit[1] ? KB_FRAMES : ((m_kenc > 0) ? m_kenc - 1 : 0);
        e_akb  = (m_akc > 0 && (ax + 125 + KB_SPEED) < BOUND) ? KB_SPEED : 0;
        e_kkb  = (m_kenc > 0 && kx >= KB_SPEED) ? -KB_SPEED : 0;
    endtask

    // ---------------- stimulus / checking ----------------
    task automatic drive(bit rst, bit p1, bit p2, int kx, int ax);
        logic [7:0] codes [4];
        int a, b;
        for (int i = 0; i < 4; i++) codes[i] = 8'($urandom_range(32'h20, 32'h2f));
        a = $urandom_range(0, 3);
        b = (a + $urandom_range(1, 3)) % 4;
        if (p1) codes[a] = P1_KEY;
        if (p2) codes[b] = P2_KEY;
        keycode_0 = codes[0];
        keycode_1 = codes[1];
        keycode_2 = codes[2];
        keycode_3 = codes[3];
        Reset_n   = rst;
        KenX      = kx[9:0];
        AkumaX    = ax[9:0];
        cur_kx    = kx;
        cur_ax    = ax;
    endtask

    task automatic step(bit rst, bit p1, bit p2, int kx, int ax);
        drive(rst, p1, p2, kx, ax);
        @(posedge frame_clk);
        model_step(rst, p1, p2, kx, ax);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, " XDist"}, XDist, cur_ax - cur_kx);
        chk({tag, " P1_State"}, int'(P1_State), phase_of(m_age[0]));
        chk({tag, " P2_State"}, int'(P2_State), phase_of(m_age[1]));
        chk({tag, " P1_Hit"}, int'(P1_Hit), int'(e_hit[0]));
        chk({tag, " P2_Hit"}, int'(P2_Hit), int'(e_hit[1]));
        chk({tag, " Akuma_Knockback"}, Akuma_Knockback, e_akb);
        chk({tag, " Ken_Knockback"}, Ken_Knockback, e_kkb);
    endtask

    typedef struct {
        bit rst, k1, k2;
        int kx, ax, reps;
        int s1, s2, h1, h2, akb, kkb;
    } row_t;

    row_t tbl [$];

    function automatic row_t R(bit rst, bit k1, bit k2, int kx, int ax, int reps,
                               int s1, int s2, int h1, int h2, int akb, int kkb);
        row_t r;
        r.rst = rst; r.k1 = k1; r.k2 = k2; r.kx = kx; r.ax = ax; r.reps = reps;
        r.s1 = s1; r.s2 = s2; r.h1 = h1; r.h2 = h2; r.akb = akb; r.kkb = kkb;
        return r;
    endfunction

    // Single P1 attack at XDist=120; akb is the push Akuma gets (0 at wall).
    task automatic add_stun_block(int kx, int ax, int akb);
        tbl.push_back(R(1,1,0,kx,ax,1, 1,0,0,0,0,0));
        tbl.push_back(R(1,0,0,kx,ax,1, 1,0,0,0,0,0));
        tbl.push_back(R(1,0,1,kx,ax,1, 1,1,0,0,0,0));
        tbl.push_back(R(1,0,0,kx,ax,1, 1,1,0,0,0,0));
        tbl.push_back(R(1,0,0,kx,ax,1, 2,1,0,0,0,0));
        tbl.push_back(R(1,0,0,kx,ax,1, 2,0,1,0,akb,0));
        tbl.push_back(R(1,0,0,kx,ax,1, 2,0,0,0,akb,0));
        tbl.push_back(R(1,0,0,kx,ax,4, 3,0,0,0,akb,0));
        tbl.push_back(R(1,0,0,kx,ax,4, 3,0,0,0,0,0));
        tbl.push_back(R(1,0,0,kx,ax,1, 0,0,0,0,0,0));
    endtask

    initial begin
        int kx, ax, r, held_hits, held_starts, last_s1;
        bit rst, p1, p2;
        model_reset();
        drive(0, 0, 0, 300, 420);

        // reset + single attack in range
        tbl.push_back(R(0,0,0,300,420,2, 0,0,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,1, 0,0,0,0,0,0));
        tbl.push_back(R(1,1,0,300,420,1, 1,0,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,3, 1,0,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,1, 2,0,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,1, 2,0,1,0,3,0));
        tbl.push_back(R(1,0,0,300,420,1, 2,0,0,0,3,0));
        tbl.push_back(R(1,0,0,300,420,4, 3,0,0,0,3,0));
        tbl.push_back(R(1,0,0,300,420,4, 3,0,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,2, 0,0,0,0,0,0));
        // trade
        tbl.push_back(R(1,1,1,300,420,1, 1,1,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,3, 1,1,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,1, 2,2,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,1, 2,2,1,1,3,-3));
        tbl.push_back(R(1,0,0,300,420,1, 2,2,0,0,3,-3));
        tbl.push_back(R(1,0,0,300,420,4, 3,3,0,0,3,-3));
        tbl.push_back(R(1,0,0,300,420,4, 3,3,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,1, 0,0,0,0,0,0));
        // out of range
        tbl.push_back(R(1,1,0,100,400,1, 1,0,0,0,0,0));
        tbl.push_back(R(1,0,0,100,400,3, 1,0,0,0,0,0));
        tbl.push_back(R(1,0,0,100,400,3, 2,0,0,0,0,0));
        tbl.push_back(R(1,0,0,100,400,8, 3,0,0,0,0,0));
        tbl.push_back(R(1,0,0,100,400,2, 0,0,0,0,0,0));
        // trade with Ken at the left wall
        tbl.push_back(R(1,1,1,2,122,1, 1,1,0,0,0,0));
        tbl.push_back(R(1,0,0,2,122,3, 1,1,0,0,0,0));
        tbl.push_back(R(1,0,0,2,122,1, 2,2,0,0,0,0));
        tbl.push_back(R(1,0,0,2,122,1, 2,2,1,1,3,0));
        tbl.push_back(R(1,0,0,2,122,1, 2,2,0,0,3,0));
        tbl.push_back(R(1,0,0,2,122,4, 3,3,0,0,3,0));
        tbl.push_back(R(1,0,0,2,122,4, 3,3,0,0,0,0));
        tbl.push_back(R(1,0,0,2,122,1, 0,0,0,0,0,0));
        // reset during third knockback frame
        tbl.push_back(R(1,1,0,300,420,1, 1,0,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,3, 1,0,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,1, 2,0,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,1, 2,0,1,0,3,0));
        tbl.push_back(R(1,0,0,300,420,1, 2,0,0,0,3,0));
        tbl.push_back(R(1,0,0,300,420,1, 3,0,0,0,3,0));
        tbl.push_back(R(0,0,0,300,420,1, 0,0,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,2, 0,0,0,0,0,0));
        // key held through reset release
        tbl.push_back(R(0,1,0,300,420,2, 0,0,0,0,0,0));
        tbl.push_back(R(1,1,0,300,420,1, 1,0,0,0,0,0));
        tbl.push_back(R(1,1,0,300,420,3, 1,0,0,0,0,0));
        tbl.push_back(R(1,1,0,300,420,1, 2,0,0,0,0,0));
        tbl.push_back(R(1,1,0,300,420,1, 2,0,1,0,3,0));
        tbl.push_back(R(1,1,0,300,420,1, 2,0,0,0,3,0));
        tbl.push_back(R(1,1,0,300,420,4, 3,0,0,0,3,0));
        tbl.push_back(R(1,1,0,300,420,4, 3,0,0,0,0,0));
        tbl.push_back(R(1,1,0,300,420,3, 0,0,0,0,0,0));
        tbl.push_back(R(1,0,0,300,420,1, 0,0,0,0,0,0));
        // stun cancel, then again with Akuma against the right wall
        add_stun_block(300, 420, 3);
        add_stun_block(388, 508, 0);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].reps; k++) begin
                step(tbl[i].rst, tbl[i].k1, tbl[i].k2, tbl[i].kx, tbl[i].ax);
                chk($sformatf("row%0d.%0d XDist", i, k), XDist, tbl[i].ax - tbl[i].kx);
                chk($sformatf("row%0d.%0d P1_State", i, k), int'(P1_State), tbl[i].s1);
                chk($sformatf("row%0d.%0d P2_State", i, k), int'(P2_State), tbl[i].s2);
                chk($sformatf("row%0d.%0d P1_Hit", i, k), int'(P1_Hit), tbl[i].h1);
                chk($sformatf("row%0d.%0d P2_Hit", i, k), int'(P2_Hit), tbl[i].h2);
                chk($sformatf("row%0d.%0d Akuma_Knockback", i, k), Akuma_Knockback, tbl[i].akb);
                chk($sformatf("row%0d.%0d Ken_Knockback", i, k), Ken_Knockback, tbl[i].kkb);
            end
        end

        // held key for 40 frames: one attack, one hit
        held_hits = 0; held_starts = 0; last_s1 = int'(P1_State);
        for (int n = 0; n < 40; n++) begin
            step(1, 1, 0, 300, 420);
            chk_model("held");
            if (P1_Hit) held_hits++;
            if (last_s1 == 0 && int'(P1_State) != 0) held_starts++;
            last_s1 = int'(P1_State);
        end
        chk("held hit count", held_hits, 1);
        chk("held attack count", held_starts, 1);
        step(1, 0, 0, 300, 420);
        chk_model("release");

        // randomized frames against the model
        kx = 300; ax = 420;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin
                        kx = $urandom_range(0, 700);
                        r  = $urandom_range(0, 320);
                        ax = kx + r - 100;
                    end
                    1: begin
                        kx = $urandom_range(0, 5);
                        r  = $urandom_range(50, 200);
                        ax = kx + r;
                    end
                    2: begin
                        ax = $urandom_range(503, 512);
                        r  = $urandom_range(60, 200);
                        kx = ax - r;
                    end
                    default: begin
                        kx = $urandom_range(0, 1023);
                        ax = $urandom_range(0, 1023);
                    end
                endcase
                if (ax < 0) ax = 0;
                if (ax > 1023) ax = 1023;
            end
            rst = ($urandom_range(0, 79) != 0);
            p1  = ($urandom_range(0, 3) == 0);
            p2  = ($urandom_range(0, 3) == 0);
            step(rst, p1, p2, kx, ax);
            chk_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
